// File: rtl/delay_responder.sv
// Request/delayed-response responder: accepts one tagged request, waits max(cfg_delay,1) cycles, holds the response until taken.
// Optional embedded protocol assertions under `define DELAY_RESPONDER_SVA_EN.
module delay_responder #(
    parameter int CNT_W  = 8,
    parameter int TAG_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              req_ready,
    input  logic              abort,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    input  logic              resp_ready,
    output logic              busy,
    output logic [STAT_W-1:0] resp_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [STAT_W-1:0]  count_q, count_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   eff_delay;
    logic               accept;

    // A zero delay is treated as the minimum one-cycle response.
    assign eff_delay = (cfg_delay == '0) ? CNT_W'(1) : cfg_delay;
    assign accept    = req_valid && req_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d = req_tag;
                    if (eff_delay == CNT_W'(1)) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = eff_delay - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // A handshake in the same cycle as abort still completes and counts.
                if (resp_ready) begin
                    state_d = IDLE;
                    count_d = count_q + STAT_W'(1);
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            count_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            count_q      <= count_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_tag   = tag_q;
    assign busy       = busy_q;
    assign resp_count = count_q;

`ifdef DELAY_RESPONDER_SVA_EN
    logic [CNT_W:0]   sva_elapsed;
    logic [CNT_W-1:0] sva_d;
    logic             sva_armed;

    // Cycles since the last acceptance, and whether a response rise is still owed to it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sva_elapsed <= '0;
            sva_d       <= '0;
            sva_armed   <= 1'b0;
        end else if (accept) begin
            sva_elapsed <= (CNT_W+1)'(1);
            sva_d       <= eff_delay;
            sva_armed   <= 1'b1;
        end else begin
            sva_elapsed <= sva_elapsed + (CNT_W+1)'(1);
            if (resp_valid_q) sva_armed <= 1'b0;
        end
    end

    a_delay_exact: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(resp_valid) |-> (sva_elapsed == {1'b0, sva_d}));
    a_delay_not_late: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == WAIT) |-> (sva_elapsed < {1'b0, sva_d}));
    a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready && !abort) |=> (resp_valid && $stable(resp_tag)));
    a_no_ready_and_valid: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready && resp_valid));
    a_one_rise_per_accept: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(resp_valid) |-> sva_armed);
`endif

endmodule

// File: tb/tb_delay_responder.sv
// Directed bench for delay_responder: table of per-cycle vectors plus hand sequences for long delay, reset in WAIT and counter wrap.
module tb_delay_responder;
    localparam int CNT_W  = 8;
    localparam int TAG_W  = 4;
    // Narrowed statistics counter keeps the wrap test short.
    localparam int STAT_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CNT_W-1:0]  cfg_delay;
    logic              req_valid;
    logic [TAG_W-1:0]  req_tag;
    logic              req_ready;
    logic              abort;
    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_ready;
    logic              busy;
    logic [STAT_W-1:0] resp_count;

    int checks   = 0;
    int failures = 0;

    delay_responder #(.CNT_W(CNT_W), .TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_delay  (cfg_delay),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .abort      (abort),
        .resp_valid (resp_valid),
        .resp_tag   (resp_tag),
        .resp_ready (resp_ready),
        .busy       (busy),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rv;
        logic [TAG_W-1:0]  tag;
        logic [CNT_W-1:0]  cfg;
        logic              ab;
        logic              rr;
        logic              e_rq;
        logic              e_vl;
        logic [TAG_W-1:0]  e_tg;
        logic              e_bz;
        logic [STAT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input int tag, input int cfg, input logic ab, input logic rr,
                       input logic e_rq, input logic e_vl, input int e_tg, input logic e_bz, input int e_cnt);
        vec_t v;
        v.rv = rv; v.tag = TAG_W'(tag); v.cfg = CNT_W'(cfg); v.ab = ab; v.rr = rr;
        v.e_rq = e_rq; v.e_vl = e_vl; v.e_tg = TAG_W'(e_tg); v.e_bz = e_bz; v.e_cnt = STAT_W'(e_cnt);
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_tag = '0; cfg_delay = '0; abort = 1'b0; resp_ready = 1'b1;
    endtask

    // Outputs packed as {req_ready, resp_valid, resp_tag, busy, resp_count}.
    function automatic logic [31:0] pack(input logic rq, input logic vl, input logic [TAG_W-1:0] tg,
                                         input logic bz, input logic [STAT_W-1:0] cnt);
        return 32'({rq, vl, tg, bz, cnt});
    endfunction

    initial begin
        int n;
        logic seen;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_state", pack(req_ready, resp_valid, resp_tag, busy, resp_count),
              pack(1'b1, 1'b0, '0, 1'b0, '0));

        //  rv tag  cfg ab rr   rq vl tg  bz cnt
        add(1, 5,   4,  0, 1,   1, 0, 0,  0, 0);   // accept T=0, D=4
        add(1, 9,   1,  0, 1,   0, 0, 0,  1, 0);   // ignored while waiting
        add(0, 0,   0,  0, 1,   0, 0, 0,  1, 0);   // cfg change ignored
        add(0, 0,   0,  0, 1,   0, 0, 0,  1, 0);
        add(0, 0,   0,  0, 1,   0, 1, 5,  1, 0);   // response at T+4
        add(1, 10,  0,  0, 1,   1, 0, 0,  0, 1);   // delay 0 -> D=1
        add(1, 11,  1,  0, 1,   0, 1, 10, 1, 1);
        add(1, 11,  1,  0, 0,   1, 0, 0,  0, 2);   // delay 1 -> D=1
        add(1, 3,   2,  0, 0,   0, 1, 11, 1, 2);
        add(0, 0,   0,  0, 0,   0, 1, 11, 1, 2);
        add(0, 0,   0,  1, 1,   0, 1, 11, 1, 2);   // abort with handshake still counts
        add(1, 6,   6,  1, 1,   1, 0, 0,  0, 3);   // abort in IDLE ignored, accept T=11
        add(0, 0,   0,  0, 1,   0, 0, 0,  1, 3);
        add(0, 0,   0,  1, 1,   0, 0, 0,  1, 3);   // abort at T+2
        add(1, 7,   2,  0, 1,   1, 0, 0,  0, 3);   // ready at T+3, accept D=2
        add(0, 0,   0,  0, 1,   0, 0, 0,  1, 3);
        add(0, 0,   0,  0, 1,   0, 1, 7,  1, 3);
        add(1, 12,  3,  0, 0,   1, 0, 0,  0, 4);   // accept D=3
        add(1, 1,   1,  0, 0,   0, 0, 0,  1, 4);
        add(1, 1,   1,  0, 0,   0, 0, 0,  1, 4);
        for (int i = 0; i < 5; i++)
            add(1, 1, 1, 0, 0,  0, 1, 12, 1, 4);   // held 5 cycles
        add(0, 0,   0,  0, 1,   0, 1, 12, 1, 4);
        add(0, 0,   0,  0, 0,   1, 0, 0,  0, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [TAG_W-1:0] tg;
            tg = vecs[i].e_vl ? resp_tag : '0;
            check($sformatf("row%0d", i), pack(req_ready, resp_valid, tg, busy, resp_count),
                  pack(vecs[i].e_rq, vecs[i].e_vl, vecs[i].e_tg, vecs[i].e_bz, vecs[i].e_cnt));
            req_valid = vecs[i].rv; req_tag = vecs[i].tag; cfg_delay = vecs[i].cfg;
            abort = vecs[i].ab; resp_ready = vecs[i].rr;
            tick();
        end
        idle_inputs();

        // Maximum delay: response exactly 255 cycles after acceptance.
        req_valid = 1'b1; req_tag = 4'h9; cfg_delay = 8'd255;
        tick();
        idle_inputs();
        n = 1;
        while (!resp_valid && n < 300) begin
            tick();
            n++;
        end
        check("delay255_latency", n, 255);
        check("delay255_tag", resp_tag, 4'h9);
        tick();
        check("delay255_count", resp_count, 6);

        // Reset during WAIT drops the request.
        req_valid = 1'b1; req_tag = 4'h4; cfg_delay = 8'd5;
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b0;
        tick();
        check("reset_in_wait", pack(req_ready, resp_valid, resp_tag, busy, resp_count),
              pack(1'b1, 1'b0, '0, 1'b0, '0));
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) seen = 1'b1;
            tick();
        end
        check("no_resp_after_reset", seen, 1'b0);

        // Back-to-back delay-1 requests until the statistics counter wraps.
        req_valid = 1'b1; req_tag = 4'h2; cfg_delay = 8'd1;
        repeat (2 * ((1 << STAT_W) - 1)) tick();
        check("count_max", resp_count, (1 << STAT_W) - 1);
        repeat (2) tick();
        check("count_wrap", resp_count, 0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
